// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The S_TRAP state is only reachable when IFETCH_MISALIGN_TRAP_EN is defined.
package ifetch_pkg;

   localparam int INST_W = 32;
   localparam int ADDR_W = 32;
   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_TRAP = 2'd2
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
      return addr & ~ADDR_W'(3);
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory and decode handshake bundle of the fetch unit.
// master = fetch unit side, slave = memory/decode environment side.
interface instr_fetch_unit_if;
   import ifetch_pkg::*;

   logic [ADDR_W-1:0] imem_addr;
   logic [INST_W-1:0] imem_rdata;
   logic              imem_ready;
   logic              inst_valid;
   logic [INST_W-1:0] inst_data;
   logic [ADDR_W-1:0] inst_pc;
   logic              inst_ready;

   modport master (
      output imem_addr, inst_valid, inst_data, inst_pc,
      input  imem_rdata, imem_ready, inst_ready
   );

   modport slave (
      input  imem_addr, inst_valid, inst_data, inst_pc,
      output imem_rdata, imem_ready, inst_ready
   );

endinterface

// File: rtl/ifetch_buf.sv
// In-order FIFO of {pc, inst} fetch entries with push, pop and flush.
// Flush wins over push; a same-cycle pop still hands out the current head.
module ifetch_buf
   import ifetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  fetch_entry_t     push_data,
   input  logic             pop,
   input  logic             flush,
   output fetch_entry_t     head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_d = rd_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign head  = mem_q[rd_q];
   assign count = cnt_q;
   assign full  = (cnt_q == CNT_W'(DEPTH));
   assign empty = (cnt_q == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS fetch front end: PC register, boot/run FSM and push/redirect arbitration.
// Define IFETCH_MISALIGN_TRAP_EN to trap on misaligned redirect targets.
module instr_fetch_unit
   import ifetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                BUF_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   instr_fetch_unit_if.master   bus,
   input  logic                 redirect_valid,
   input  logic [ADDR_W-1:0]    redirect_pc,
   output logic                 misalign
);

   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              head_valid;
   logic              push;
   logic              pop;
   fetch_entry_t      buf_head;
   logic [CNT_W-1:0]  buf_count;
   logic              buf_full;
   logic              buf_empty;

   assign head_valid = !buf_empty;
   assign pop        = head_valid && bus.inst_ready;
   assign push       = (state_q == S_RUN) && bus.imem_ready && (!buf_full || pop)
                       && !redirect_valid;

`ifdef IFETCH_MISALIGN_TRAP_EN
   logic misalign_q, misalign_d;
`endif

   // Redirect outranks everything; otherwise the PC only moves on a push.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
      misalign_d = misalign_q;
`endif
      if (redirect_valid) begin
         pc_d = align_word(redirect_pc);
`ifdef IFETCH_MISALIGN_TRAP_EN
         if (redirect_pc[1:0] != 2'b00) begin
            state_d    = S_TRAP;
            misalign_d = 1'b1;
         end else begin
            state_d    = S_RUN;
            misalign_d = 1'b0;
         end
`else
         state_d = S_RUN;
`endif
      end else begin
         case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (push) pc_d = pc_q + PC_STEP;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_BOOT;
         pc_q    <= RESET_PC;
`ifdef IFETCH_MISALIGN_TRAP_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   ifetch_buf #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data ('{pc: pc_q, inst: bus.imem_rdata}),
      .pop       (pop),
      .flush     (redirect_valid),
      .head      (buf_head),
      .count     (buf_count),
      .full      (buf_full),
      .empty     (buf_empty)
   );

   assert property (@(posedge clk) disable iff (!rst_n) buf_count <= CNT_W'(BUF_DEPTH));

   // Head fields are gated so decode never sees a stale entry.
   assign bus.imem_addr  = pc_q;
   assign bus.inst_valid = head_valid;
   assign bus.inst_data  = head_valid ? buf_head.inst : '0;
   assign bus.inst_pc    = head_valid ? buf_head.pc   : '0;

`ifdef IFETCH_MISALIGN_TRAP_EN
   assign misalign = misalign_q;
`else
   assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_instr_fetch_unit;
   import ifetch_pkg::*;

   localparam int          DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        misalign;

   instr_fetch_unit_if bus ();

   instr_fetch_unit #(
      .RESET_PC  (RST_PC),
      .BUF_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .misalign       (misalign)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   assign bus.imem_rdata = mem_word(bus.imem_addr);

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: the buffer is a plain queue of fetched words.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc;
   bit          m_boot;
   bit          m_trap;

   typedef struct {
      bit          do_reset;
      bit          rv;
      logic [31:0] rpc;
      bit          ir;
      bit          dr;
      bit          ev;
      logic [31:0] epc;
      logic [31:0] eaddr;
   } vec_t;

   vec_t vecs[$];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit rv, input logic [31:0] rpc,
                                input bit ir, input bit dr);
      redirect_valid = rv;
      redirect_pc    = rpc;
      bus.imem_ready = ir;
      bus.inst_ready = dr;
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc   = RST_PC;
      m_boot = 1'b1;
      m_trap = 1'b0;
   endtask

   task automatic model_step();
      bit pop;
      bit push;
      pop = (mq.size() > 0) && bus.inst_ready;
      if (redirect_valid) begin
         mq.delete();
         m_pc   = {redirect_pc[31:2], 2'b00};
         m_boot = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
         m_trap = (redirect_pc[1:0] != 2'b00);
`endif
      end else if (m_boot) begin
         m_boot = 1'b0;
      end else if (!m_trap) begin
         push = bus.imem_ready && ((mq.size() < DEPTH) || pop);
         if (pop) void'(mq.pop_front());
         if (push) begin
            mq.push_back('{pc: m_pc, inst: mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
         end
      end else if (pop) begin
         void'(mq.pop_front());
      end
   endtask

   task automatic check_model(input string tag);
      bit v;
      v = (mq.size() > 0);
      checkOutput({tag, " valid"}, {31'b0, bus.inst_valid}, {31'b0, v});
      checkOutput({tag, " inst_pc"}, bus.inst_pc, v ? mq[0].pc : 32'h0);
      checkOutput({tag, " inst_data"}, bus.inst_data, v ? mq[0].inst : 32'h0);
      checkOutput({tag, " misalign"}, {31'b0, misalign}, {31'b0, m_trap});
      if (!m_trap) checkOutput({tag, " imem_addr"}, bus.imem_addr, m_pc);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reset is asserted mid-cycle to exercise the asynchronous path.
   task automatic reset_dut();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("reset inst_valid", {31'b0, bus.inst_valid}, 32'h0);
      checkOutput("reset inst_data", bus.inst_data, 32'h0);
      checkOutput("reset inst_pc", bus.inst_pc, 32'h0);
      checkOutput("reset misalign", {31'b0, misalign}, 32'h0);
      checkOutput("reset imem_addr", bus.imem_addr, RST_PC);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic add_vec(input bit rst, input bit rv, input logic [31:0] rpc, input bit ir,
                          input bit dr, input bit ev, input logic [31:0] epc,
                          input logic [31:0] eaddr);
      vecs.push_back('{do_reset: rst, rv: rv, rpc: rpc, ir: ir, dr: dr,
                       ev: ev, epc: epc, eaddr: eaddr});
   endtask

   initial begin
      bus.imem_ready = 1'b1;
      bus.inst_ready = 1'b1;
      model_reset();

      // Streaming, fill-up, redirect with pop, memory stall, wrap at top of memory.
      add_vec(1, 0, 32'h0,         1, 1, 0, 32'h0,         32'h0);
      add_vec(0, 0, 32'h0,         1, 1, 0, 32'h0,         32'h0);
      add_vec(0, 0, 32'h0,         1, 1, 1, 32'h0,         32'h4);
      add_vec(0, 0, 32'h0,         1, 1, 1, 32'h4,         32'h8);
      add_vec(0, 0, 32'h0,         1, 1, 1, 32'h8,         32'hC);
      add_vec(0, 0, 32'h0,         1, 0, 1, 32'hC,         32'h10);
      add_vec(0, 0, 32'h0,         1, 0, 1, 32'hC,         32'h14);
      add_vec(0, 1, 32'h40,        1, 1, 1, 32'hC,         32'h14);
      add_vec(0, 0, 32'h0,         1, 1, 0, 32'h0,         32'h40);
      add_vec(0, 0, 32'h0,         0, 1, 1, 32'h40,        32'h44);
      add_vec(0, 0, 32'h0,         0, 1, 0, 32'h0,         32'h44);
      add_vec(0, 0, 32'h0,         0, 1, 0, 32'h0,         32'h44);
      add_vec(0, 0, 32'h0,         1, 1, 0, 32'h0,         32'h44);
      add_vec(0, 1, 32'hFFFF_FFF8, 1, 1, 1, 32'h44,        32'h48);
      add_vec(0, 0, 32'h0,         1, 1, 0, 32'h0,         32'hFFFF_FFF8);
      add_vec(0, 0, 32'h0,         1, 1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
      add_vec(0, 0, 32'h0,         1, 1, 1, 32'hFFFF_FFFC, 32'h0);
      add_vec(0, 0, 32'h0,         1, 1, 1, 32'h0,         32'h4);
      // Decode stalled from reset: two words run ahead, then the address freezes.
      add_vec(1, 0, 32'h0,         1, 0, 0, 32'h0,         32'h0);
      add_vec(0, 0, 32'h0,         1, 0, 0, 32'h0,         32'h0);
      add_vec(0, 0, 32'h0,         1, 0, 1, 32'h0,         32'h4);
      add_vec(0, 0, 32'h0,         1, 0, 1, 32'h0,         32'h8);
      add_vec(0, 0, 32'h0,         1, 0, 1, 32'h0,         32'h8);
      add_vec(0, 0, 32'h0,         1, 1, 1, 32'h0,         32'h8);
      add_vec(0, 0, 32'h0,         1, 1, 1, 32'h4,         32'hC);
      add_vec(0, 0, 32'h0,         1, 1, 1, 32'h8,         32'h10);

      foreach (vecs[i]) begin
         if (vecs[i].do_reset) reset_dut();
         checkOutput($sformatf("vec%0d inst_valid", i), {31'b0, bus.inst_valid},
                     {31'b0, vecs[i].ev});
         checkOutput($sformatf("vec%0d inst_pc", i), bus.inst_pc,
                     vecs[i].ev ? vecs[i].epc : 32'h0);
         checkOutput($sformatf("vec%0d inst_data", i), bus.inst_data,
                     vecs[i].ev ? mem_word(vecs[i].epc) : 32'h0);
         checkOutput($sformatf("vec%0d imem_addr", i), bus.imem_addr, vecs[i].eaddr);
         applyStimulus(vecs[i].rv, vecs[i].rpc, vecs[i].ir, vecs[i].dr);
         tick();
      end

      // Misaligned redirect target.
      reset_dut();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      tick();
      tick();
      checkOutput("mis pre valid", {31'b0, bus.inst_valid}, 32'h1);
      applyStimulus(1'b1, 32'd18, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
`ifdef IFETCH_MISALIGN_TRAP_EN
      for (int k = 0; k < 5; k++) begin
         checkOutput($sformatf("trap%0d misalign", k), {31'b0, misalign}, 32'h1);
         checkOutput($sformatf("trap%0d inst_valid", k), {31'b0, bus.inst_valid}, 32'h0);
         tick();
      end
      applyStimulus(1'b1, 32'd20, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("untrap misalign", {31'b0, misalign}, 32'h0);
      checkOutput("untrap inst_valid", {31'b0, bus.inst_valid}, 32'h0);
      checkOutput("untrap imem_addr", bus.imem_addr, 32'd20);
      tick();
      checkOutput("untrap inst_valid2", {31'b0, bus.inst_valid}, 32'h1);
      checkOutput("untrap inst_pc", bus.inst_pc, 32'd20);
`else
      checkOutput("mis inst_valid", {31'b0, bus.inst_valid}, 32'h0);
      checkOutput("mis imem_addr", bus.imem_addr, 32'd16);
      checkOutput("mis misalign", {31'b0, misalign}, 32'h0);
      tick();
      checkOutput("mis inst_pc", bus.inst_pc, 32'd16);
      checkOutput("mis inst_data", bus.inst_data, mem_word(32'd16));
      checkOutput("mis misalign2", {31'b0, misalign}, 32'h0);
`endif

      // Randomized traffic against the reference model.
      reset_dut();
      for (int n = 0; n < 1500; n++) begin
         logic [31:0] rpc;
         bit          rv;
         bit          ir;
         bit          dr;
         check_model("rand");
         rv  = ($urandom_range(0, 9) == 0);
         rpc = $urandom;
         if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
         ir  = ($urandom_range(0, 3) != 0);
         dr  = ($urandom_range(0, 4) >= 2);
         applyStimulus(rv, rpc, ir, dr);
         tick();
      end

      // Reset landing in the middle of streaming fetches.
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      tick();
      reset_dut();
      for (int n = 0; n < 4; n++) begin
         check_model("post");
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
